// File: rtl/seq_multiplier.sv
// Shift-free sequential multiplier: adds x into acc y times, counting cnt down to the external zero flag.
// Build option SEQ_MULT_SWAP_EN: iterate over min(x,y) so the loop is as short as possible.
module seq_multiplier (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  input  logic        aeq0,
  output logic [7:0]  cnt,
  output logic [15:0] prod,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_cnt;
  logic [7:0]  r_mreg;
  logic [15:0] r_acc;
  logic [15:0] r_prod;

  logic [7:0]  w_load_cnt;
  logic [7:0]  w_load_mreg;

`ifdef SEQ_MULT_SWAP_EN
  // Smaller operand becomes the iteration count; the product is unchanged.
  assign w_load_cnt  = (y > x) ? x : y;
  assign w_load_mreg = (y > x) ? y : x;
`else
  assign w_load_cnt  = y;
  assign w_load_mreg = x;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (aeq0)  w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= 8'd0;
      r_mreg <= 8'd0;
      r_acc  <= 16'd0;
      r_prod <= 16'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_cnt  <= w_load_cnt;
            r_mreg <= w_load_mreg;
            r_acc  <= 16'd0;
          end
        end
        RUN: begin
          // aeq0 is the only guard on the decrement, so cnt stops at zero.
          if (aeq0) begin
            r_prod <= r_acc;
          end else begin
            r_acc <= r_acc + {8'd0, r_mreg};
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign cnt  = r_cnt;
  assign prod = r_prod;
  assign busy = (r_state != IDLE);
  assign done = (r_state == DONE);

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier; the comparator is modelled as aeq0 = (cnt == 0).
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  x;
  logic [7:0]  y;
  logic        aeq0;
  logic [7:0]  cnt;
  logic [15:0] prod;
  logic        busy;
  logic        done;

  seq_multiplier dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .x    (x),
    .y    (y),
    .aeq0 (aeq0),
    .cnt  (cnt),
    .prod (prod),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;
  assign aeq0 = (cnt == 8'd0);

  typedef struct {
    logic [15:0] prod;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] last_prod = 16'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_lat(input logic [7:0] a, input logic [7:0] b);
`ifdef SEQ_MULT_SWAP_EN
    return ((b > a) ? int'(a) : int'(b)) + 1;
`else
    return int'(b) + 1;
`endif
  endfunction

  // Called at a negedge; returns at the negedge just after the accepting edge k.
  task automatic launch(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    start  = 1'b1;
    x      = a;
    y      = b;
    e.prod = 16'(a) * 16'(b);
    e.lat  = exp_lat(a, b);
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    x     = 8'($urandom);
    y     = 8'($urandom);
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("prod_held_at_start", 32'(prod), 32'(last_prod));
  endtask

  // c0 = edges after k already consumed by the caller.
  task automatic wait_done(input string tag, input int c0, input int budget);
    exp_t e;
    int   c;
    c = c0;
    while (c < budget) begin
      @(negedge clk);
      c++;
      if (done) break;
    end
    if (!done) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
      if (sb.size() != 0) void'(sb.pop_front());
      return;
    end
    chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk({tag, "_latency"}, 32'(c), 32'(e.lat));
    chk({tag, "_prod"}, 32'(prod), 32'(e.prod));
    chk({tag, "_cnt_zero"}, 32'(cnt), 32'd0);
    chk({tag, "_busy_in_done"}, 32'(busy), 32'd1);
    last_prod = e.prod;
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) n++;
    end
  endtask

  initial begin
    int n_done;
    int abort_at;
    rst   = 1'b1;
    start = 1'b0;
    x     = 8'd0;
    y     = 8'd0;
    #1;
    chk("rst_cnt", 32'(cnt), 32'd0);
    chk("rst_prod", 32'(prod), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    launch(8'd3, 8'd5);
    wait_done("m3x5", 0, 400);

    launch(8'd200, 8'd0);
    wait_done("m200x0", 0, 400);
    launch(8'd0, 8'd7);
    wait_done("m0x7", 0, 400);

    launch(8'd255, 8'd255);
    wait_done("m255x255", 0, 400);

    // A second start while RUN must be dropped.
    launch(8'd4, 8'd10);
    @(negedge clk);
    start = 1'b1;
    x     = 8'd9;
    y     = 8'd9;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    wait_done("m4x10", 3, 400);
    count_done(30, n_done);
    chk("ignored_start_no_done", 32'(n_done), 32'd0);
    chk("ignored_start_sb_empty", 32'(sb.size()), 32'd0);

    // Asynchronous abort mid-RUN.
`ifdef SEQ_MULT_SWAP_EN
    abort_at = 4;
`else
    abort_at = 8;
`endif
    launch(8'd7, 8'd20);
    repeat (abort_at - 1) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_cnt", 32'(cnt), 32'd0);
    chk("abort_prod", 32'(prod), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    void'(sb.pop_front());
    last_prod = 16'd0;
    count_done(3, n_done);
    @(negedge clk);
    rst = 1'b0;
    count_done(30, n_done);
    chk("abort_no_done", 32'(n_done), 32'd0);
    launch(8'd2, 8'd3);
    wait_done("m2x3_after_rst", 0, 400);

    launch(8'd2, 8'd100);
    wait_done("m2x100", 0, 400);

    for (int i = 0; i < 6; i++) begin
      launch(8'($urandom), 8'($urandom_range(0, 40)));
      wait_done("rand", 0, 400);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005 x  input  8  multiplicand, unsigned.
REQ-006 y  input  8  multiplier, unsigned; the iteration count.
REQ-007 aeq0  input  1  zero flag from the external equal-to-zero comparator, which is driven by cnt; combinational, same cycle.
REQ-008 cnt  output  8  iteration-count register; drives the comparator input.
REQ-009 prod  output  16  product register, unsigned.
REQ-010 busy  output  1  high whenever the state is not IDLE.
REQ-011 done  output  1  one-cycle completion pulse.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 In IDLE, when start=1 at an edge, the block SHALL load cnt<=y, load an internal 8-bit mreg<=x, clear the 16-bit acc, and go to RUN.
REQ-014 In RUN with aeq0=0, the block SHALL update acc<=acc+{8'b0,mreg} and cnt<=cnt-1 at each edge, and stay in RUN.
REQ-015 In RUN with aeq0=1, the block SHALL load prod<=acc, leave acc and cnt unchanged, and go to DONE.
REQ-016 In DONE, the block SHALL drive done=1 for exactly one cycle and then return to IDLE at the next edge.
REQ-017 Latency: if start is accepted at edge k, done SHALL be high between edges k+N+1 and k+N+2, where N is the loaded cnt value (0..255).
REQ-018 The result SHALL be exact modulo nothing: acc and prod are 16 bits, so 255*255=65025 is exact and no overflow is possible.
REQ-019 cnt SHALL never decrement below 0; decrement is gated by aeq0=0 only.
REQ-020 start in RUN or DONE SHALL be ignored, with no queuing; start held high in DONE is accepted only after the return to IDLE.
REQ-021 x and y SHALL be sampled only at the accepting edge; later changes SHALL have no effect on the running operation.
REQ-022 prod SHALL hold its last result until the next completion; it SHALL NOT be cleared at start.
REQ-023 N=0 SHALL give one RUN cycle and prod=0.

Reset
REQ-024 rst=1 SHALL immediately force state=IDLE, cnt=0, mreg=0, acc=0, prod=0, busy=0 and done=0, independent of clk.
REQ-025 Reset during RUN or DONE SHALL abort the operation without a done pulse; the first start after rst deasserts SHALL behave as from power-up.

Configuration
REQ-026 Macro SEQ_MULT_SWAP_EN.
- Defined: at load, if y>x then cnt<=x and mreg<=y; otherwise cnt<=y and mreg<=x. N becomes min(x,y).
- Undefined: cnt<=y and mreg<=x always, and N=y.
- prod is identical in both builds.

Verification
REQ-027 The bench SHALL model the comparator as aeq0=(cnt==0).
REQ-028 x=3, y=5, start at edge k -> done high between edges k+6 and k+7, prod=15, busy high from k+1 through k+7.
REQ-029 x=200, y=0 -> done between edges k+1 and k+2, prod=0; a second run x=0, y=7 -> prod=0, done at k+8.
REQ-030 x=255, y=255 -> prod=65025 after 256 RUN cycles; cnt=0 when done is high.
REQ-031 Start at k with x=4, y=10; pulse start again with x=9, y=9 at k+3 -> second start ignored, prod=40, done exactly once.
REQ-032 Assert rst asynchronously mid-RUN (x=7, y=20, at k+8) -> all outputs 0 immediately, no done pulse; then x=2, y=3 -> prod=6.
REQ-033 x=2, y=100 -> with SEQ_MULT_SWAP_EN defined, done at k+3 to k+4; without it, done at k+101 to k+102; prod=200 in both builds.
